// File: rtl/count_sequence_checker_pkg.sv
// Shared types and defaults for the count sequence checker: FSM states,
// step classes and the default count/counter widths.
package count_sequence_checker_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        RUN
    } state_t;

    typedef enum logic [2:0] {
        HOLD,
        STEP,
        WRAP,
        RESTART,
        ILLEGAL
    } step_t;

endpackage

// File: rtl/count_sequence_checker_if.sv
// Bundle between the upstream counter side (master) and the checker (slave).
interface count_sequence_checker_if
    import count_sequence_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);

    logic [WIDTH-1:0] q;
    logic             clear;
    logic             wrap_pulse;
    logic             match_pulse;
    logic             restart_pulse;
    logic             err;
    logic [CNT_W-1:0] wrap_count;
    logic [CNT_W-1:0] err_count;
    logic [WIDTH-1:0] last_q;

    modport master (
        output q, clear,
        input  wrap_pulse, match_pulse, restart_pulse, err,
        input  wrap_count, err_count, last_q
    );

    modport slave (
        input  q, clear,
        output wrap_pulse, match_pulse, restart_pulse, err,
        output wrap_count, err_count, last_q
    );

endinterface

// File: rtl/count_sequence_checker_sat_counter.sv
// Saturating incrementer with synchronous active-low reset and synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/count_sequence_checker.sv
// Samples an upstream count each rising edge and classifies every step between
// consecutive samples, flagging wraps, restarts, a match value and illegal steps.
module count_sequence_checker
    import count_sequence_checker_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] MATCH_VAL = WIDTH'('hA),
    parameter int               CNT_W     = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    count_sequence_checker_if.slave bus
);

    localparam logic [WIDTH-1:0] MAXV = '1;

    state_t           state;
    step_t            cls;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic             in_run;
    logic             wrap_inc;
    logic             err_inc;
    logic             wrap_p;
    logic             match_p;
    logic             restart_p;
    logic             err_r;

    // Wrap is tested before step because MAXV+1 overflows to 0 in WIDTH bits.
    always_comb begin
        cls = ILLEGAL;
        if (s0 == s1) begin
            cls = HOLD;
        end else if ((s1 == MAXV) && (s0 == '0)) begin
            cls = WRAP;
        end else if (s0 == '0) begin
            cls = RESTART;
        end else if ((s1 != MAXV) && (s0 == WIDTH'(s1 + 1'b1))) begin
            cls = STEP;
        end
    end

    assign in_run   = (state == RUN);
    assign wrap_inc = in_run && (cls == WRAP);
    assign err_inc  = in_run && (cls == ILLEGAL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= EMPTY;
            s0        <= '0;
            s1        <= '0;
            wrap_p    <= 1'b0;
            match_p   <= 1'b0;
            restart_p <= 1'b0;
            err_r     <= 1'b0;
        end else if (bus.clear) begin
            // Dropping s1 keeps a stale pre-clear sample from forming a pair.
            state     <= ONE;
            s0        <= bus.q;
            s1        <= '0;
            wrap_p    <= 1'b0;
            match_p   <= 1'b0;
            restart_p <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            s1 <= s0;
            s0 <= bus.q;
            case (state)
                EMPTY:   state <= ONE;
                ONE:     state <= RUN;
                default: state <= RUN;
            endcase
            wrap_p    <= wrap_inc;
            restart_p <= in_run && (cls == RESTART);
            match_p   <= in_run && (s0 == MATCH_VAL) && (s0 != s1);
            if (err_inc) begin
                err_r <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (bus.clear),
        .inc   (wrap_inc),
        .count (bus.wrap_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (bus.clear),
        .inc   (err_inc),
        .count (bus.err_count)
    );

    assign bus.wrap_pulse    = wrap_p;
    assign bus.match_pulse   = match_p;
    assign bus.restart_pulse = restart_p;
    assign bus.err           = err_r;
    assign bus.last_q        = s0;

endmodule
